wlan_scrambler_ctrl: RTL and testbench
======================================

# wlan_scrambler_ctrl

Frame sequencer for the 802.11a transmit scrambler. One `start` command runs one PPDU DATA field through the x^7+x^4+1 scrambling LFSR, bit-serially. The field is: 16 SERVICE zero bits, then 8·`psdu_len` PSDU bits pulled from upstream, then 6 tail bits, then zero pad bits up to a whole number of OFDM symbols. The block sits between the MAC byte-to-bit serializer and the convolutional encoder, and owns the LFSR, seed loading and tail zeroing.

## Interface
- `LEN_W`, 12: PSDU length width in bytes (max 4095).
- `NDBPS_W`, 9: width of `ndbps` (data bits per OFDM symbol, 24..216).
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low.
- `start` input 1: one-cycle frame request; sampled only in IDLE.
- `seed` input 7: initial LFSR state {s7..s1}, sampled with `start`.
- `psdu_len` input LEN_W: PSDU bytes, sampled with `start`; 0 legal.
- `ndbps` input NDBPS_W: bits per symbol, sampled with `start`.
- `in_valid` input 1: upstream PSDU bit valid.
- `in_data` input 1: upstream PSDU bit.
- `in_ready` output 1: PSDU bit accepted this cycle when `in_valid`&`in_ready`.
- `out_valid` output 1: scrambled bit valid.
- `out_data` output 1: scrambled bit.
- `out_ready` input 1: downstream accepts when `out_valid`&`out_ready`.
- `busy` output 1: high from the cycle after accepted `start` until `done`.
- `done` output 1: one-cycle pulse after the last pad bit transfers.

## Operation
- LFSR: seq = s7 ^ s4. On each output transfer: {s7..s1} <= {s6..s1, seq}. `out_data` = data ^ seq. The LFSR never advances without a transfer.
- Seed load at accepted `start`. If `seed`==0, load 7'b1011101 instead.
- States: IDLE, SERVICE, PSDU, TAIL, PAD, DONE.
- IDLE: if `start`, go to SERVICE, clear counters, latch parameters.
- SERVICE: data=0, `out_valid`=1. After 16 transfers, go to PSDU, or to TAIL if `psdu_len`==0.
- PSDU: `out_valid`=`in_valid`, `in_ready`=`out_ready`, data=`in_data`. This is a combinational pass-through with zero latency. After 8·`psdu_len` transfers, go to TAIL.
- TAIL: `out_valid`=1, `out_data` forced to 0. The LFSR still advances. After 6 transfers, go to DONE if the symbol counter has wrapped to 0, else go to PAD.
- PAD: data=0, scrambled. Transfer until the symbol counter wraps to 0, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Symbol counter: counts 0..`ndbps`-1 per output transfer and wraps. Total bits = ceil((22+8·L)/ndbps)·ndbps.
- PSDU bit counter is LEN_W+3 bits wide, with no overflow.
- `start` while not IDLE is ignored.
- `in_ready`=0 outside PSDU.
- Upstream stalls and downstream stalls are independent, and each is arbitrarily long.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `in_ready`=0, `busy`=0, `done`=0.
  - State = IDLE.
  - LFSR = 7'b1011101.
  - All counters = 0.
- First SERVICE bit is presented the cycle after `start`.
- One bit per cycle when `out_ready`=1 and (in PSDU) `in_valid`=1.
- `done` is asserted the cycle after the final PAD/TAIL transfer. The next `start` is accepted the cycle after `done`.
- Reset asserted mid-frame aborts immediately to the reset state. No `done` is produced, and partial output is discarded by downstream.

## Structure
- Package `wlan_scr_pkg` holds:
  - state enum;
  - SERVICE_BITS=16, TAIL_BITS=6;
  - DEFAULT_SEED=7'b1011101;
  - LFSR tap positions.
- Sub-module `scrambler_lfsr`: ports `load`, `load_val[7:1]`, `adv`, output `seq`; async active-low reset to DEFAULT_SEED.
- Controller FSM, counters and muxing live in the top.

## Test plan
- Seed 7'h7F, L=0, ndbps=24, `out_ready`=1.
  - First 8 SERVICE outputs are 0,0,0,0,1,1,1,0.
  - Total 24 transfers; output bits 16..21 are 0.
  - `done` pulses once.
- Seed 0 → behaves identically to seed 7'b1011101; first 4 outputs are 0,1,1,0.
- L=1, ndbps=24, `in_data`=all 1 → 48 output transfers: 16 SERVICE, 8 PSDU, 6 tail, 18 pad. PSDU outputs equal ~seq.
- Random `in_valid`/`out_ready` stalls, L=3, ndbps=48 → the output stream is bit-identical to the no-stall run. The LFSR does not advance on stall cycles.
- `start` pulsed during PSDU → ignored; frame length unchanged.
- Reset during PAD → all outputs return to reset values next edge. A new `start` then yields the full frame from the new seed.

Source files
------------

// File: rtl/wlan_scr_pkg.sv
// Shared types and constants for the 802.11a transmit scrambler sequencer.
package wlan_scr_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SERVICE = 3'd1,
    S_PSDU    = 3'd2,
    S_TAIL    = 3'd3,
    S_PAD     = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  // Fallback seed: an all-zero LFSR would lock up, so zero seeds map here.
  localparam logic [7:1] DEFAULT_SEED = 7'b1011101;

  // x^7 + x^4 + 1 feedback taps, as indices into {s7..s1}.
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 4;

endpackage

// File: rtl/scrambler_lfsr.sv
// 7-bit scrambling LFSR; advances only when the owning frame logic says a bit moved.
module scrambler_lfsr
  import wlan_scr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:1] load_val,
  input  logic       adv,
  output logic       seq
);

  logic [7:1] s_q, s_d;

  assign seq = s_q[TAP_HI] ^ s_q[TAP_LO];

  // Next state: a seed load takes priority over a shift.
  always_comb begin
    s_d = s_q;
    if (load)     s_d = load_val;
    else if (adv) s_d = {s_q[6:1], seq};
  end

  // State register, resets to the default seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s_q <= DEFAULT_SEED;
    else        s_q <= s_d;
  end

endmodule

// File: rtl/wlan_scrambler_ctrl.sv
// Frame sequencer: SERVICE / PSDU / TAIL / PAD bit-serial scrambling for one PPDU DATA field.
module wlan_scrambler_ctrl
  import wlan_scr_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int NDBPS_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [6:0]         seed,
  input  logic [LEN_W-1:0]   psdu_len,
  input  logic [NDBPS_W-1:0] ndbps,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic               out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = LEN_W + 3;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NDBPS_W-1:0] sym_q;
  logic [NDBPS_W-1:0] ndbps_q;
  logic [LEN_W-1:0]   len_q;
  logic               busy_q, done_q;

  logic               seq;
  logic               xfer;
  logic               sym_wrap;
  logic               lfsr_load;
  logic [7:1]         load_val;
  logic [CNT_W-1:0]   psdu_last;

  assign xfer      = out_valid & out_ready;
  assign sym_wrap  = (sym_q == ndbps_q - NDBPS_W'(1));
  assign psdu_last = {len_q, 3'b000} - CNT_W'(1);
  assign lfsr_load = (state_q == S_IDLE) && start;
  assign load_val  = (seed == 7'd0) ? DEFAULT_SEED : seed;
  assign busy      = busy_q;
  assign done      = done_q;

  scrambler_lfsr u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (load_val),
    .adv      (xfer),
    .seq      (seq)
  );

  // Per-state bit muxing; PSDU is a zero-latency pass-through so this stays combinational.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      S_SERVICE, S_PAD: begin
        out_valid = 1'b1;
        out_data  = seq;
      end
      S_PSDU: begin
        out_valid = in_valid;
        out_data  = in_data ^ seq;
        in_ready  = out_ready;
      end
      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = 1'b0;
      end
      default: ;
    endcase
  end

  // Frame FSM with phase bit counter, symbol counter and registered status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      ndbps_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (xfer) sym_q <= sym_wrap ? '0 : sym_q + NDBPS_W'(1);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SERVICE;
            cnt_q   <= '0;
            sym_q   <= '0;
            len_q   <= psdu_len;
            ndbps_q <= ndbps;
            busy_q  <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (xfer) begin
            if (cnt_q == CNT_W'(SERVICE_BITS - 1)) begin
              cnt_q   <= '0;
              state_q <= (len_q == '0) ? S_TAIL : S_PSDU;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PSDU: begin
          if (xfer) begin
            if (cnt_q == psdu_last) begin
              cnt_q   <= '0;
              state_q <= S_TAIL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_TAIL: begin
          if (xfer) begin
            if (cnt_q == CNT_W'(TAIL_BITS - 1)) begin
              cnt_q <= '0;
              if (sym_wrap) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_PAD;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAD: begin
          if (xfer && sym_wrap) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wlan_scrambler_ctrl.sv
// Scoreboard bench for wlan_scrambler_ctrl: expected bits queued at stimulus, popped by a monitor.
module tb_wlan_scrambler_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  seed;
  logic [11:0] psdu_len;
  logic [8:0]  ndbps;
  logic        in_valid, in_data, in_ready;
  logic        out_valid, out_data, out_ready;
  logic        busy, done;

  wlan_scrambler_ctrl #(.LEN_W(12), .NDBPS_W(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .psdu_len  (psdu_len),
    .ndbps     (ndbps),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  logic pbits[0:255];
  logic got[0:255];
  logic ref_bits[0:255];
  int   xfer_cnt, done_cnt;
  bit   frame_done, mon_en;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scrambler: builds the whole expected output stream of one frame.
  task automatic build_exp(input logic [6:0] sd, input int L, input int nd);
    logic [6:0] s;
    logic q, d;
    int nb, total;
    s     = (sd == 7'd0) ? 7'b1011101 : sd;
    nb    = 8 * L;
    total = ((22 + nb + nd - 1) / nd) * nd;
    for (int i = 0; i < total; i++) begin
      q = s[6] ^ s[3];
      if (i < 16)           d = q;
      else if (i < 16 + nb) d = pbits[i-16] ^ q;
      else if (i < 22 + nb) d = 1'b0;
      else                  d = q;
      exp_q.push_back(d);
      s = {s[5:0], q};
    end
  endtask

  function automatic int pack(input int first, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(got[first+i]);
    return v;
  endfunction

  // Monitor: mid-low-phase sampling of every output transfer and the done pulse.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_out: unexpected output bit %0d at %0t", out_data, $time);
        end else begin
          chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
        if (xfer_cnt < 256) got[xfer_cnt] = out_data;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        frame_done = 1'b1;
      end
    end
  end

  // One frame: mode 0 = PSDU all ones, mode 1 = fixed pattern.
  task automatic run_frame(input logic [6:0] sd, input int L, input int nd, input int mode,
                           input bit stall, input int inj_cyc, input int abort_cyc);
    int  cyc, pidx;
    bit  aborted;
    for (int i = 0; i < 256; i++)
      pbits[i] = (mode == 0) ? 1'b1 : logic'(((i * 37 + 11) % 7) < 3);
    build_exp(sd, L, nd);
    @(negedge clk);
    seed = sd; psdu_len = 12'(L); ndbps = 9'(nd);
    start = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    pidx = 0; frame_done = 1'b0; xfer_cnt = 0; done_cnt = 0; mon_en = 1'b1;
    @(negedge clk);
    cyc = 0; aborted = 1'b0;
    while (!frame_done && !aborted && cyc < 4000) begin
      start = (cyc == inj_cyc);
      if (start) begin seed = 7'h11; psdu_len = 12'd5; ndbps = 9'd100; end
      if (cyc == 2) chk("busy_mid", int'(busy), 1);
      if (cyc == abort_cyc) begin
        mon_en = 1'b0;
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        out_ready = stall ? logic'($urandom_range(0, 3) != 0) : 1'b1;
        in_valid  = stall ? logic'($urandom_range(0, 2) != 0) : 1'b1;
        in_data   = (pidx < 8 * L) ? pbits[pidx] : 1'b0;
        #1;
        if (in_valid && in_ready) pidx++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("frame_finished", int'(frame_done), 1);
      chk("queue_drained", exp_q.size(), 0);
      chk("busy_idle", int'(busy), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; seed = '0; psdu_len = '0; ndbps = 9'd24;
    in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_done",      int'(done),      0);
    @(negedge clk);
    reset = 1'b1;

    // Seed 7F, empty PSDU: 22 bits padded to one 24-bit symbol.
    run_frame(7'h7F, 0, 24, 0, 1'b0, -1, -1);
    chk("svc_first8", pack(0, 8), 8'b00001110);
    chk("tail_zero", pack(16, 6), 0);
    chk("xfers_L0", xfer_cnt, 24);
    chk("done_once_L0", done_cnt, 1);

    // Zero seed falls back to 1011101.
    run_frame(7'h00, 0, 24, 0, 1'b0, -1, -1);
    chk("seed0_first4", pack(0, 4), 4'b0110);
    chk("xfers_seed0", xfer_cnt, 24);

    // One all-ones PSDU byte: outputs are inverted scrambler bits 16..23.
    run_frame(7'h7F, 1, 24, 0, 1'b0, -1, -1);
    chk("psdu_inv", pack(16, 8), 8'b00110110);
    chk("tail_zero_L1", pack(24, 6), 0);
    chk("xfers_L1", xfer_cnt, 48);
    chk("done_once_L1", done_cnt, 1);

    // Same frame without and with random stalls on both sides.
    run_frame(7'h2B, 3, 48, 1, 1'b0, -1, -1);
    for (int i = 0; i < 48; i++) ref_bits[i] = got[i];
    chk("xfers_nostall", xfer_cnt, 48);
    run_frame(7'h2B, 3, 48, 1, 1'b1, -1, -1);
    chk("xfers_stall", xfer_cnt, 48);
    begin
      int diffs = 0;
      for (int i = 0; i < 48; i++) if (got[i] !== ref_bits[i]) diffs++;
      chk("stall_same_stream", diffs, 0);
    end

    // Start pulse mid-PSDU is ignored.
    run_frame(7'h3C, 2, 24, 1, 1'b0, 20, -1);
    chk("xfers_ignored_start", xfer_cnt, 48);
    chk("done_ignored_start", done_cnt, 1);

    // Reset during PAD, then a clean frame from a new seed.
    run_frame(7'h7F, 0, 216, 0, 1'b0, -1, 60);
    #2;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_data",  int'(out_data),  0);
    chk("abort_in_ready",  int'(in_ready),  0);
    chk("abort_busy",      int'(busy),      0);
    chk("abort_done",      int'(done),      0);
    chk("abort_no_done",   done_cnt,        0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    run_frame(7'h55, 1, 24, 1, 1'b0, -1, -1);
    chk("xfers_after_abort", xfer_cnt, 48);
    chk("done_after_abort", done_cnt, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
